// File: rtl/ps2_rx_frame_if.sv
// ps2_rx_frame_if
//   Bundles the PS/2 pin inputs, the receive enable and the byte/status
//   outputs of the PS/2 frame receiver.
//   master : receiver side (samples pins, drives rx_* / err / busy)
//   slave  : connector/consumer side (drives pins and rx_en, observes results)
//   Signals:
//     ps2c, ps2d    raw PS/2 clock and data, asynchronous to clk
//     rx_en         1 = accept new frames (start-bit detection only)
//     rx_done_tick  one-cycle pulse, rx_data holds a new byte
//     rx_data       last good byte
//     parity_err    one-cycle pulse, frame dropped on odd-parity failure
//     frame_err     one-cycle pulse, frame dropped on start/stop/timeout
//     busy          frame in progress
interface ps2_rx_frame_if;
  logic       ps2c;
  logic       ps2d;
  logic       rx_en;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (
    input  ps2c, ps2d, rx_en,
    output rx_done_tick, rx_data, parity_err, frame_err, busy
  );

  modport slave (
    output ps2c, ps2d, rx_en,
    input  rx_done_tick, rx_data, parity_err, frame_err, busy
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame
//   Synchronises and deglitches the raw PS/2 clock/data lines and
//   deserialises each 11-bit frame (start, d0..d7 LSB first, odd parity,
//   stop) into one byte. Scan codes are not interpreted.
//   Ports:
//     clk   system clock
//     rst   asynchronous reset, active high
//     bus   ps2_rx_frame_if.master (pins, rx_en, byte and status outputs)
//
//   state | meaning
//   IDLE  | waiting for a start bit on a filtered falling edge
//   DATA  | shifting d0..d7, parity and stop; inter-edge timeout running
//   CHECK | one cycle to validate stop/parity and report the result
module ps2_rx_frame #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int TO_W        = 16
) (
  input  logic           clk,
  input  logic           rst,
  ps2_rx_frame_if.master bus
);

  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t                state_q, state_d;
  logic [1:0]            c_sync, d_sync;
  logic [FILTER_LEN-1:0] c_sr;
  logic                  filt_q, filt_d;
  logic                  fall_tick;
  logic                  ps2d_s;
  logic [9:0]            b_q, b_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [TO_W-1:0]       to_q, to_d;
  logic [7:0]            data_q, data_d;
  logic                  done_q, done_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;

  // Synchroniser and filter history reset to the idle-high line level so no
  // spurious falling edge is seen when reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
      c_sr   <= '1;
      filt_q <= 1'b1;
    end else begin
      c_sync <= {c_sync[0], bus.ps2c};
      d_sync <= {d_sync[0], bus.ps2d};
      c_sr   <= {c_sr[FILTER_LEN-2:0], c_sync[1]};
      filt_q <= filt_d;
    end
  end

  always_comb begin
    filt_d = filt_q;
    if (&c_sr)       filt_d = 1'b1;
    else if (~|c_sr) filt_d = 1'b0;
  end

  assign fall_tick = filt_q & ~filt_d;
  assign ps2d_s    = d_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      b_q     <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      data_q  <= data_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    data_d  = data_q;
    done_d  = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall_tick && bus.rx_en) begin
          if (!ps2d_s) begin
            state_d = DATA;
            cnt_d   = 4'd9;
            to_d    = '0;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (fall_tick) begin
          // After ten shifts b_q = {stop, parity, d7..d0}.
          b_d  = {ps2d_s, b_q[9:1]};
          to_d = '0;
          if (cnt_q == 4'd0) state_d = CHECK;
          else               cnt_d   = cnt_q - 4'd1;
        end else if (to_q == TO_LAST) begin
          ferr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (!b_q[9])          ferr_d = 1'b1;
        else if (!(^b_q[8:0])) perr_d = 1'b1;
        else begin
          data_d = b_q[7:0];
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_done_tick = done_q;
  assign bus.rx_data      = data_q;
  assign bus.parity_err   = perr_q;
  assign bus.frame_err    = ferr_q;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
module tb_ps2_rx_frame;
  localparam int HALF  = 40;   // PS/2 half bit period in clk cycles (scaled for simulation)
  localparam int TO_CY = 400;  // scaled inter-edge timeout

  localparam int K_DONE = 0;
  localparam int K_PERR = 1;
  localparam int K_FERR = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ps2_rx_frame_if bus ();

  ps2_rx_frame #(.FILTER_LEN(8), .TIMEOUT_CYC(TO_CY), .TO_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] last_good = 8'h00;
  logic       chk_busy0 = 1'b0;
  int         busy_viol = 0;
  logic       prev_hi = 1'b0;

  function automatic string kname(int k);
    case (k)
      K_DONE:  return "rx_done_tick";
      K_PERR:  return "parity_err";
      default: return "frame_err";
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every result pulse pops one expectation.
  always @(negedge clk) begin
    int   n_hi;
    int   kind;
    exp_t e;
    if (!rst) begin
      n_hi = int'(bus.rx_done_tick) + int'(bus.parity_err) + int'(bus.frame_err);
      if (chk_busy0 && bus.busy) busy_viol++;
      if (n_hi != 0) begin
        kind = bus.rx_done_tick ? K_DONE : (bus.parity_err ? K_PERR : K_FERR);
        check("one_pulse_at_a_time", n_hi, 1);
        check("pulse_not_consecutive", {31'd0, prev_hi}, 0);
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_pulse: got %s, expected none", kname(kind));
        end else begin
          e = exp_q.pop_front();
          n_cmp++;
          if (kind != e.kind) begin
            n_err++;
            $display("FAIL pulse_kind: got %s, expected %s", kname(kind), kname(e.kind));
          end
          check("rx_data_at_pulse", {24'd0, bus.rx_data}, {24'd0, e.data});
        end
      end
      prev_hi = (n_hi != 0);
    end else begin
      prev_hi = 1'b0;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Reference model: classify a full frame by the protocol rules.
  task automatic expect_frame(input logic [7:0] data, input logic par, input logic stop);
    exp_t e;
    if (!stop) begin
      e.kind = K_FERR; e.data = last_good;
    end else if ((($countones(data) + int'(par)) % 2) != 1) begin
      e.kind = K_PERR; e.data = last_good;
    end else begin
      last_good = data;
      e.kind = K_DONE; e.data = data;
    end
    exp_q.push_back(e);
  endtask

  task automatic expect_ferr();
    exp_t e;
    e.kind = K_FERR; e.data = last_good;
    exp_q.push_back(e);
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  // Drive the first nbits bits of bits[] (bit 0 first). Data changes while
  // ps2c is high; glitch_at inserts a 3-cycle low pulse in that bit's high phase.
  task automatic send_bits(input logic [10:0] bits, input int nbits,
                           input int glitch_at, input int en_drop_at);
    for (int i = 0; i < nbits; i++) begin
      bus.ps2d = bits[i];
      if (glitch_at == i) begin
        wait_cyc(HALF/2);
        bus.ps2c = 1'b0;
        wait_cyc(3);
        bus.ps2c = 1'b1;
        wait_cyc(HALF/2 - 3);
      end else begin
        wait_cyc(HALF);
      end
      bus.ps2c = 1'b0;
      wait_cyc(HALF);
      bus.ps2c = 1'b1;
      if (en_drop_at == i) bus.rx_en = 1'b0;
    end
    bus.ps2d = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int glitch_at, input int en_drop_at);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    if (bus.rx_en) expect_frame(d, par, stop);
    send_bits(bits, 11, glitch_at, en_drop_at);
    wait_cyc(2*HALF);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    int         k;
    bus.ps2c  = 1'b1;
    bus.ps2d  = 1'b1;
    bus.rx_en = 1'b1;
    wait_cyc(4);
    @(negedge clk);
    check("reset_rx_done_tick", {31'd0, bus.rx_done_tick}, 0);
    check("reset_rx_data", {24'd0, bus.rx_data}, 0);
    check("reset_parity_err", {31'd0, bus.parity_err}, 0);
    check("reset_frame_err", {31'd0, bus.frame_err}, 0);
    check("reset_busy", {31'd0, bus.busy}, 0);
    @(posedge clk);
    rst = 1'b0;
    wait_cyc(20);

    send_frame(8'h75, good_par(8'h75), 1'b1, -1, -1);
    send_frame(8'hF0, good_par(8'hF0), 1'b1, -1, -1);
    send_frame(8'h75, good_par(8'h75), 1'b1, -1, -1);
    send_frame(8'h1D, good_par(8'h1D), 1'b1, -1, -1);
    send_frame(8'h5A, ~good_par(8'h5A), 1'b1, -1, -1);
    check("rx_data_held_after_parity_err", {24'd0, bus.rx_data}, 32'h1D);

    bus.ps2c = 1'b0;
    wait_cyc(3);
    bus.ps2c = 1'b1;
    wait_cyc(30);
    check("busy_after_idle_glitch", {31'd0, bus.busy}, 0);
    send_frame(8'h23, good_par(8'h23), 1'b1, 4, -1);
    check("rx_data_after_glitch_frame", {24'd0, bus.rx_data}, 32'h23);

    // Start + 5 data bits, then the clock stops.
    expect_ferr();
    send_bits({1'b1, good_par(8'h3C), 8'h3C, 1'b0}, 6, -1, -1);
    wait_cyc(TO_CY + 100);
    check("busy_after_timeout", {31'd0, bus.busy}, 0);
    send_frame(8'h29, good_par(8'h29), 1'b1, -1, -1);

    // Lone falling edge with data high in IDLE is a bad start bit.
    expect_ferr();
    send_bits(11'h7FF, 1, -1, -1);
    wait_cyc(2*HALF);

    send_bits({1'b1, good_par(8'h6B), 8'h6B, 1'b0}, 4, -1, -1);
    rst = 1'b1;
    last_good = 8'h00;
    wait_cyc(2);
    @(negedge clk);
    check("rst_mid_rx_data", {24'd0, bus.rx_data}, 0);
    check("rst_mid_busy", {31'd0, bus.busy}, 0);
    check("rst_mid_pulses", {29'd0, bus.rx_done_tick, bus.parity_err, bus.frame_err}, 0);
    @(posedge clk);
    rst = 1'b0;
    wait_cyc(20);
    send_frame(8'h6B, good_par(8'h6B), 1'b1, -1, -1);

    bus.rx_en = 1'b0;
    busy_viol = 0;
    chk_busy0 = 1'b1;
    send_frame(8'h6B, good_par(8'h6B), 1'b1, -1, -1);
    chk_busy0 = 1'b0;
    check("busy_stays_0_when_disabled", busy_viol, 0);
    check("rx_data_after_disabled_frame", {24'd0, bus.rx_data}, 32'h6B);
    bus.rx_en = 1'b1;
    wait_cyc(10);

    for (int n = 0; n < 20; n++) begin
      d = 8'($urandom);
      k = int'($urandom_range(0, 5));
      send_frame(d, (k == 0) ? ~good_par(d) : good_par(d), (k == 1) ? 1'b0 : 1'b1,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : -1,
                 ($urandom_range(0, 4) == 0) ? 3 : -1);
      bus.rx_en = 1'b1;
    end

    wait_cyc(200);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
